p405s_mac_add_arb: RTL and testbench

- Sequencer and arbiter for the shared 33-bit carry-in/carry-out MAC adder (SUM[32:0], CO = carry out of bit 31).
- Shares the adder between two requesters: R0, the MAC accumulate path (priority), and R1, the iterative divide/multi-word path.
- Each request is a single-word 33-bit add or a double-word 65-bit add. A double-word add is chained over two adder cycles using the registered carry.
- Sits between the MAC/divide control and the adder instance. Drives the adder operands from registers and captures its combinational result.

---
 rtl/p405s_mac_add_arb.sv | 214 +++++++++++++++++++++
 tb/tb_p405s_mac_add_arb.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/p405s_mac_add_arb.sv
// p405s_mac_add_arb
// Sequencer and arbiter for the shared 33-bit MAC adder (SUM[32:0], CO = carry
// out of bit 31). Two requesters share the adder: R0 (MAC accumulate, priority)
// and R1 (iterative divide / multi-word). A single-word op is one 33-bit add; a
// double-word op is a 65-bit add chained over two adder cycles, with the low
// word's CO fed back as the high word's carry-in.
//
// Handshake: a requester raises REQ with DBL/A/B/CI stable and holds them until
// its GNT pulses. GNT is a one-cycle accept pulse: the operands are sampled on
// the clock edge that ends the GNT cycle and never at any other time. A REQ
// withdrawn before GNT is simply forgotten. The result appears as a one-cycle
// RES_VLD pulse tagged with RES_ID; RES_SUM/RES_CO hold until the next pulse.
//
// Timing from the accept cycle T:
//   single: T accept, T+1 LO, T+2 DONE (RES_VLD)
//   double: T accept, T+1 LO, T+2 HI, T+3 DONE (RES_VLD)
// DONE accepts a new request exactly like IDLE, so results and grants can
// coincide and back-to-back ops run without a bubble.

module p405s_mac_add_arb #(
    parameter int STARVE_LIM = 3,
    parameter int CNT_W      = 2
) (
    input  logic        CB,
    input  logic        resetCore_N,

    input  logic        R0_REQ,
    input  logic        R0_DBL,
    input  logic [64:0] R0_A,
    input  logic [64:0] R0_B,
    input  logic        R0_CI,

    input  logic        R1_REQ,
    input  logic        R1_DBL,
    input  logic [64:0] R1_A,
    input  logic [64:0] R1_B,
    input  logic        R1_CI,

    output logic        R0_GNT,
    output logic        R1_GNT,

    output logic [32:0] ADD_A,
    output logic [32:0] ADD_B,
    output logic        ADD_CI,
    input  logic [32:0] ADD_SUM,
    input  logic        ADD_CO,

    output logic        RES_VLD,
    output logic        RES_ID,
    output logic [64:0] RES_SUM,
    output logic        RES_CO,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

    // FSM and datapath registers
    state_e             state_q;
    logic               dbl_q;      // current op is a double-word add
    logic               id_q;       // current op owner
    logic [32:0]        a_hi_q;     // high words kept for the HI cycle
    logic [32:0]        b_hi_q;
    logic [31:0]        lo_q;       // low-word sum of a double op
    logic [32:0]        add_a_q;
    logic [32:0]        add_b_q;
    logic               add_ci_q;
    logic               res_vld_q;
    logic               res_id_q;
    logic [64:0]        res_sum_q;
    logic               res_co_q;

    // Starvation counter: R0 grants given while R1 was waiting
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    // Arbitration signals
    logic               can_accept;
    logic               starved;
    logic               r0_win;
    logic               r1_win;
    logic               accept;
    logic               sel_dbl;
    logic               sel_ci;
    logic [64:0]        sel_a;
    logic [64:0]        sel_b;

    // Arbitration: only IDLE/DONE may accept. R0 has priority unless R1 has
    // been passed over STARVE_LIM times in a row. GNT is also held low while
    // reset is asserted so every output is quiet during reset.
    always_comb begin
        can_accept = resetCore_N && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        starved    = R1_REQ && (cnt_q == LIM);
        r0_win     = can_accept && R0_REQ && !starved;
        r1_win     = can_accept && R1_REQ && (!R0_REQ || starved);
        accept     = r0_win || r1_win;
        sel_dbl    = r1_win ? R1_DBL : R0_DBL;
        sel_ci     = r1_win ? R1_CI  : R0_CI;
        sel_a      = r1_win ? R1_A   : R0_A;
        sel_b      = r1_win ? R1_B   : R0_B;
    end

    // Next starvation count: clears whenever R1 is not waiting or is served,
    // counts R0 grants that jumped ahead of R1, saturating at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (!R1_REQ || r1_win) begin
            cnt_d = '0;
        end else if (r0_win && (cnt_q != LIM)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Starvation counter register
    always_ff @(posedge CB or negedge resetCore_N) begin
        if (!resetCore_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Sequencer: accept/launch, low word, high word, result pulse
    always_ff @(posedge CB or negedge resetCore_N) begin
        if (!resetCore_N) begin
            state_q   <= ST_IDLE;
            dbl_q     <= 1'b0;
            id_q      <= 1'b0;
            a_hi_q    <= '0;
            b_hi_q    <= '0;
            lo_q      <= '0;
            add_a_q   <= '0;
            add_b_q   <= '0;
            add_ci_q  <= 1'b0;
            res_vld_q <= 1'b0;
            res_id_q  <= 1'b0;
            res_sum_q <= '0;
            res_co_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    // The result pulse lasts exactly the DONE cycle.
                    res_vld_q <= 1'b0;
                    if (accept) begin
                        dbl_q  <= sel_dbl;
                        id_q   <= r1_win;
                        a_hi_q <= sel_a[64:32];
                        b_hi_q <= sel_b[64:32];
                        // Low word of a double op has bit 32 forced to 0 so
                        // SUM[32] of that cycle is the plain 32-bit carry.
                        if (sel_dbl) begin
                            add_a_q <= {1'b0, sel_a[31:0]};
                            add_b_q <= {1'b0, sel_b[31:0]};
                        end else begin
                            add_a_q <= sel_a[32:0];
                            add_b_q <= sel_b[32:0];
                        end
                        add_ci_q <= sel_ci;
                        state_q  <= ST_LO;
                    end else begin
                        // Adder operands hold their last value while idle.
                        state_q <= ST_IDLE;
                    end
                end

                ST_LO: begin
                    if (dbl_q) begin
                        lo_q     <= ADD_SUM[31:0];
                        add_a_q  <= a_hi_q;
                        add_b_q  <= b_hi_q;
                        add_ci_q <= ADD_CO;
                        state_q  <= ST_HI;
                    end else begin
                        res_sum_q <= {32'b0, ADD_SUM};
                        res_co_q  <= ADD_CO;
                        res_id_q  <= id_q;
                        res_vld_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end

                ST_HI: begin
                    res_sum_q <= {ADD_SUM, lo_q};
                    res_co_q  <= ADD_CO;
                    res_id_q  <= id_q;
                    res_vld_q <= 1'b1;
                    state_q   <= ST_DONE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign R0_GNT  = r0_win;
    assign R1_GNT  = r1_win;
    assign ADD_A   = add_a_q;
    assign ADD_B   = add_b_q;
    assign ADD_CI  = add_ci_q;
    assign RES_VLD = res_vld_q;
    assign RES_ID  = res_id_q;
    assign RES_SUM = res_sum_q;
    assign RES_CO  = res_co_q;
    assign BUSY    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_p405s_mac_add_arb.sv
// Directed bench for p405s_mac_add_arb. The adder is modelled combinationally
// here; all expected values are hand-computed constants.

module tb_p405s_mac_add_arb;

    logic        CB;
    logic        resetCore_N;
    logic        R0_REQ, R0_DBL, R0_CI;
    logic [64:0] R0_A, R0_B;
    logic        R1_REQ, R1_DBL, R1_CI;
    logic [64:0] R1_A, R1_B;
    logic        R0_GNT, R1_GNT;
    logic [32:0] ADD_A, ADD_B;
    logic        ADD_CI;
    logic [32:0] ADD_SUM;
    logic        ADD_CO;
    logic        RES_VLD, RES_ID, RES_CO, BUSY;
    logic [64:0] RES_SUM;

    int n_checks = 0;
    int n_fail   = 0;

    logic [0:0] exp_q[$];
    logic [0:0] e;
    logic       pend_id;

    p405s_mac_add_arb #(.STARVE_LIM(3), .CNT_W(2)) dut (
        .CB(CB), .resetCore_N(resetCore_N),
        .R0_REQ(R0_REQ), .R0_DBL(R0_DBL), .R0_A(R0_A), .R0_B(R0_B), .R0_CI(R0_CI),
        .R1_REQ(R1_REQ), .R1_DBL(R1_DBL), .R1_A(R1_A), .R1_B(R1_B), .R1_CI(R1_CI),
        .R0_GNT(R0_GNT), .R1_GNT(R1_GNT),
        .ADD_A(ADD_A), .ADD_B(ADD_B), .ADD_CI(ADD_CI),
        .ADD_SUM(ADD_SUM), .ADD_CO(ADD_CO),
        .RES_VLD(RES_VLD), .RES_ID(RES_ID), .RES_SUM(RES_SUM), .RES_CO(RES_CO),
        .BUSY(BUSY)
    );

    // Adder model: 33-bit sum, CO is the carry out of bit 31
    logic [33:0] full_sum;
    logic [32:0] lo_sum;
    assign full_sum = {1'b0, ADD_A} + {1'b0, ADD_B} + {33'b0, ADD_CI};
    assign lo_sum   = {1'b0, ADD_A[31:0]} + {1'b0, ADD_B[31:0]} + {32'b0, ADD_CI};
    assign ADD_SUM  = full_sum[32:0];
    assign ADD_CO   = lo_sum[32];

    // Clock
    initial CB = 1'b0;
    always #5 CB = ~CB;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge
    task automatic cyc();
        @(posedge CB);
        #2;
    endtask

    task automatic clear_reqs();
        R0_REQ = 0; R0_DBL = 0; R0_A = '0; R0_B = '0; R0_CI = 0;
        R1_REQ = 0; R1_DBL = 0; R1_A = '0; R1_B = '0; R1_CI = 0;
    endtask

    initial begin
        clear_reqs();
        resetCore_N = 1'b0;

        // ---- reset state
        cyc(); cyc(); #1;
        check("rst_busy", BUSY, 0);
        check("rst_add_a", ADD_A, 0);
        check("rst_vld", RES_VLD, 0);
        check("rst_sum", RES_SUM, 0);
        resetCore_N = 1'b1;
        #1;
        check("idle_gnt", {R0_GNT, R1_GNT}, 0);

        // ---- R0 single: 0xFFFFFFFF + 1
        cyc();
        R0_REQ = 1; R0_DBL = 0; R0_A = 65'h0_FFFFFFFF; R0_B = 65'h1; R0_CI = 0;
        #1;
        check("t1_r0_gnt", R0_GNT, 1);
        check("t1_r1_gnt", R1_GNT, 0);
        cyc(); R0_REQ = 0; #1;
        check("t1_lo_a", ADD_A, 33'h0FFFFFFFF);
        check("t1_lo_b", ADD_B, 33'h1);
        check("t1_lo_vld", RES_VLD, 0);
        check("t1_lo_busy", BUSY, 1);
        cyc(); #1;
        check("t1_vld", RES_VLD, 1);
        check("t1_id", RES_ID, 0);
        check("t1_sum", RES_SUM, 65'h1_00000000);
        check("t1_co", RES_CO, 1);
        cyc(); #1;
        check("t1_vld_off", RES_VLD, 0);
        check("t1_idle", BUSY, 0);
        check("t1_sum_hold", RES_SUM, 65'h1_00000000);
        check("t1_add_hold", ADD_A, 33'h0FFFFFFFF);

        // ---- R1 double: 0x1_FFFFFFFF + 1
        cyc();
        R1_REQ = 1; R1_DBL = 1; R1_A = 65'h0_00000001_FFFFFFFF; R1_B = 65'h1; R1_CI = 0;
        #1;
        check("t2_r1_gnt", R1_GNT, 1);
        cyc(); R1_REQ = 0; #1;
        check("t2_lo_a", ADD_A, 33'h0FFFFFFFF);
        check("t2_lo_ci", ADD_CI, 0);
        check("t2_lo_vld", RES_VLD, 0);
        cyc(); #1;
        check("t2_hi_ci", ADD_CI, 1);
        check("t2_hi_a", ADD_A, 33'h1);
        check("t2_hi_b", ADD_B, 33'h0);
        check("t2_hi_vld", RES_VLD, 0);
        cyc(); #1;
        check("t2_vld", RES_VLD, 1);
        check("t2_id", RES_ID, 1);
        check("t2_sum", RES_SUM, 65'h0_00000002_00000000);
        check("t2_co", RES_CO, 0);
        cyc(); #1;
        check("t2_idle", BUSY, 0);

        // ---- both requesting singles continuously: R0 R0 R0 R1 ...
        exp_q = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        pend_id = 0;
        cyc();
        R0_REQ = 1; R0_DBL = 0; R0_A = 65'h5;   R0_B = 65'h7;  R0_CI = 0;
        R1_REQ = 1; R1_DBL = 0; R1_A = 65'h100; R1_B = 65'h23; R1_CI = 1;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) cyc();
            #1;
            check("t3_vld", RES_VLD, ((c >= 2) && (c % 2 == 0)) ? 1 : 0);
            if (RES_VLD) begin
                check("t3_res_id", RES_ID, pend_id);
                check("t3_res_sum", RES_SUM, pend_id ? 65'h124 : 65'hC);
            end
            check("t3_gnt_slot", R0_GNT | R1_GNT, (c % 2 == 0) ? 1 : 0);
            check("t3_onehot", R0_GNT & R1_GNT, 0);
            if (R0_GNT | R1_GNT) begin
                if (exp_q.size() == 0) begin
                    check("t3_extra_gnt", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("t3_order", R1_GNT, e);
                end
                pend_id = R1_GNT;
            end
        end
        cyc(); R0_REQ = 0; R1_REQ = 0; #1;
        check("t3_last_vld", RES_VLD, 1);
        check("t3_last_id", RES_ID, 1);
        check("t3_last_sum", RES_SUM, 65'h124);
        check("t3_q_empty", exp_q.size(), 0);
        cyc(); #1;
        check("t3_idle", BUSY, 0);

        // ---- R0 double, R1 arrives during LO/HI and waits for DONE
        cyc();
        R0_REQ = 1; R0_DBL = 1; R0_A = 65'h0_00000003_80000000; R0_B = 65'h0_00000004_80000000; R0_CI = 1;
        #1;
        check("t4_r0_gnt", R0_GNT, 1);
        cyc();
        R0_REQ = 0;
        R1_REQ = 1; R1_DBL = 0; R1_A = 65'h2; R1_B = 65'h3; R1_CI = 0;
        #1;
        check("t4_lo_no_gnt", R1_GNT, 0);
        cyc(); #1;
        check("t4_hi_no_gnt", R1_GNT, 0);
        check("t4_hi_ci", ADD_CI, 1);
        check("t4_hi_a", ADD_A, 33'h3);
        cyc(); #1;
        check("t4_done_gnt", R1_GNT, 1);
        check("t4_vld", RES_VLD, 1);
        check("t4_id", RES_ID, 0);
        check("t4_sum", RES_SUM, 65'h0_00000008_00000001);
        check("t4_co", RES_CO, 0);
        cyc(); R1_REQ = 0; #1;
        check("t4_r1_lo_a", ADD_A, 33'h2);
        cyc(); #1;
        check("t4_r1_vld", RES_VLD, 1);
        check("t4_r1_id", RES_ID, 1);
        check("t4_r1_sum", RES_SUM, 65'h5);
        cyc(); #1;
        check("t4_idle", BUSY, 0);

        // ---- reset during HI of an R1 double, R1_REQ held throughout
        cyc();
        R1_REQ = 1; R1_DBL = 1; R1_A = 65'h0_00000001_FFFFFFFF; R1_B = 65'h1; R1_CI = 0;
        #1;
        check("t5_gnt", R1_GNT, 1);
        cyc(); #1;
        check("t5_lo_no_gnt", R1_GNT, 0);
        check("t5_lo_busy", BUSY, 1);
        cyc(); #1;
        check("t5_hi_ci", ADD_CI, 1);
        resetCore_N = 1'b0;
        #1;
        check("t5_rst_busy", BUSY, 0);
        check("t5_rst_add_a", ADD_A, 0);
        check("t5_rst_ci", ADD_CI, 0);
        check("t5_rst_gnt", R1_GNT, 0);
        check("t5_rst_sum", RES_SUM, 0);
        check("t5_rst_vld", RES_VLD, 0);
        cyc(); #1;
        check("t5_rst_hold_vld", RES_VLD, 0);
        cyc();
        resetCore_N = 1'b1;
        #1;
        check("t5_regrant", R1_GNT, 1);
        check("t5_post_vld", RES_VLD, 0);
        cyc(); R1_REQ = 0; #1;
        check("t5_lo_vld", RES_VLD, 0);
        cyc(); #1;
        check("t5_hi_vld", RES_VLD, 0);
        cyc(); #1;
        check("t5_vld", RES_VLD, 1);
        check("t5_id", RES_ID, 1);
        check("t5_sum", RES_SUM, 65'h0_00000002_00000000);
        cyc(); #1;
        check("t5_idle", BUSY, 0);

        // ---- R1_REQ dips low once: counter clears, R1 waits 3 more R0 grants
        exp_q = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        pend_id = 0;
        cyc();
        R0_REQ = 1; R0_DBL = 0; R0_A = 65'h5;   R0_B = 65'h7;  R0_CI = 0;
        R1_DBL = 0; R1_A = 65'h100; R1_B = 65'h23; R1_CI = 1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) cyc();
            R1_REQ = (c != 3);
            #1;
            check("t6_vld", RES_VLD, ((c >= 2) && (c % 2 == 0)) ? 1 : 0);
            if (RES_VLD) begin
                check("t6_res_id", RES_ID, pend_id);
            end
            check("t6_gnt_slot", R0_GNT | R1_GNT, (c % 2 == 0) ? 1 : 0);
            if (R0_GNT | R1_GNT) begin
                if (exp_q.size() == 0) begin
                    check("t6_extra_gnt", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("t6_order", R1_GNT, e);
                end
                pend_id = R1_GNT;
            end
        end
        cyc(); R0_REQ = 0; R1_REQ = 0; #1;
        check("t6_last_vld", RES_VLD, 1);
        check("t6_last_id", RES_ID, 1);
        check("t6_q_empty", exp_q.size(), 0);
        cyc(); #1;
        check("t6_idle", BUSY, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
